// File: rtl/cmp_arb_pkg.sv
// Shared types for the round-robin comparator arbiter: FSM state encoding
// and the packed result-flag struct.
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } flags_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude comparator. Defining SIGNED_CMP_EN switches the
// operands to two's-complement interpretation; otherwise they are unsigned.
module cmp_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

`ifdef SIGNED_CMP_EN
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign a_s = $signed(a);
  assign b_s = $signed(b);
  assign gt  = (a_s > b_s);
`else
  assign gt  = (a > b);
`endif

  assign eq = (a == b);
  assign lt = !eq && !gt;

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparator between NUM_REQ requesters.
// Comparison mode follows the SIGNED_CMP_EN macro (see cmp_core).
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ*WIDTH-1:0]     A_Bus,
  input  logic [NUM_REQ*WIDTH-1:0]     B_Bus,
  output logic [NUM_REQ-1:0]           Grant,
  output logic                         Done,
  output logic [$clog2(NUM_REQ)-1:0]   Done_Id,
  output logic                         A_E_B,
  output logic                         A_G_B,
  output logic                         A_L_B,
  output logic                         Busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t             state;
  state_t             state_n;
  logic [ID_W-1:0]    last_served;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    winner;
  logic               found;
  logic [NUM_REQ-1:0] grant_n;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               load;
  logic               capture;
  logic               retire;

  logic [WIDTH-1:0]   opa_p0;
  logic [WIDTH-1:0]   opb_p0;
  logic [ID_W-1:0]    id_p0;
  flags_t             cmp_res;
  flags_t             flags_p1;

  // Search upward from the requester after last_served, wrapping around.
  // An unknown Req bit fails the if-test and is therefore ignored.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_served) + k) % NUM_REQ);
      if (!found) begin
        if (Req[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  always_comb begin
    grant_n = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        grant_n[i] = 1'b1;
        sel_a      = A_Bus[i*WIDTH +: WIDTH];
        sel_b      = B_Bus[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = COMPARE;
          load    = 1'b1;
        end
      end
      COMPARE: begin
        state_n = RESPOND;
        capture = 1'b1;
      end
      RESPOND: begin
        state_n = IDLE;
        retire  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Stage p0: operands and winner index captured on the IDLE->COMPARE edge.
  always_ff @(posedge Clk) begin
    if (load) begin
      opa_p0 <= sel_a;
      opb_p0 <= sel_b;
      id_p0  <= winner;
    end
  end

  cmp_core #(
    .WIDTH(WIDTH)
  ) u_cmp_core (
    .a  (opa_p0),
    .b  (opb_p0),
    .eq (cmp_res.eq),
    .gt (cmp_res.gt),
    .lt (cmp_res.lt)
  );

  // Stage p1: flags registered on the COMPARE->RESPOND edge and held until
  // the next transaction reaches RESPOND.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Grant       <= '0;
      Done        <= 1'b0;
      Done_Id     <= '0;
      flags_p1    <= '0;
      last_served <= ID_W'(NUM_REQ - 1);
    end else begin
      Done <= capture;
      if (load)        Grant <= grant_n;
      else if (retire) Grant <= '0;
      if (capture) begin
        flags_p1 <= cmp_res;
        Done_Id  <= id_p0;
      end
      if (retire) last_served <= id_p0;
    end
  end

  assign A_E_B = flags_p1.eq;
  assign A_G_B = flags_p1.gt;
  assign A_L_B = flags_p1.lt;
  assign Busy  = (state != IDLE);

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the comparator; SHALL be 2..8.
REQ-002 Parameter WIDTH, default 4, operand width in bits.
REQ-003 Port Clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 Port Reset  input  1  synchronous, active-high reset.
REQ-005 Port Req  input  NUM_REQ  per-requester request level.
REQ-006 Port A_Bus  input  NUM_REQ*WIDTH  packed A operands; requester i at bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-007 Port B_Bus  input  NUM_REQ*WIDTH  packed B operands, same packing as A_Bus.
REQ-008 Port Grant  output  NUM_REQ  registered one-hot grant; all zero when nothing is granted.
REQ-009 Port Done  output  1  one-cycle pulse; result flags valid for the granted requester.
REQ-010 Port Done_Id  output  clog2(NUM_REQ)  index of the requester the current result belongs to.
REQ-011 Port A_E_B, A_G_B, A_L_B  output  1 each  registered comparison result flags.
REQ-012 Port Busy  output  1  high in every state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, COMPARE and RESPOND.
REQ-014 IDLE: Req is sampled; if any bit is set, the winner SHALL be the first set bit found searching upward, with wrap-around, from (last_served+1) mod NUM_REQ.
REQ-015 IDLE with a winner: on the next edge the block SHALL latch the winner's A and B, set Grant to its one-hot code and enter COMPARE.
REQ-016 IDLE with no Req bit set: the block SHALL stay in IDLE with Grant at zero.
REQ-017 COMPARE: on the next edge the block SHALL register the flags computed from the latched operands and enter RESPOND.
REQ-018 RESPOND: Done SHALL be 1 for exactly one cycle and Done_Id SHALL equal the winner's index.
REQ-019 RESPOND: on the next edge last_served SHALL be set to the winner, Grant SHALL clear and the FSM SHALL return to IDLE.
REQ-020 Latency: a Req first seen in IDLE in cycle N SHALL give Grant in N+1 and Done in N+2; the next arbitration SHALL occur no earlier than N+3.
REQ-021 Operands SHALL be sampled only on the IDLE-to-COMPARE edge; later changes on A_Bus, B_Bus or Req SHALL NOT affect the result in flight.
REQ-022 Exactly one of A_E_B, A_G_B and A_L_B SHALL be 1 after the first completed transaction.
REQ-023 The flags SHALL hold their value until the next RESPOND.
REQ-024 A Req still high when the FSM returns to IDLE SHALL be treated as a new request and arbitrated normally under round-robin.
REQ-025 With every Req bit held high, grants SHALL rotate 0,1,...,NUM_REQ-1,0,...; no requester SHALL wait longer than NUM_REQ transactions.
REQ-026 An X or Z value on a Req bit SHALL be treated as 0.

Reset
REQ-027 Reset high at an edge SHALL force state IDLE, Grant 0, Done 0, Done_Id 0, all three flags 0, Busy 0 and last_served NUM_REQ-1, so requester 0 has first priority.
REQ-028 Reset asserted in COMPARE or RESPOND SHALL abort the transaction, and no Done pulse SHALL be produced for it.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-030 Macro SIGNED_CMP_EN defined: operands SHALL be compared as WIDTH-bit two's-complement values (4'b1000 < 4'b0111).
REQ-031 Macro SIGNED_CMP_EN undefined: operands SHALL be compared as unsigned values (4'b1000 > 4'b0111); all other behaviour SHALL be identical.

Structure
REQ-032 Shared package cmp_arb_pkg SHALL hold the FSM state enum (IDLE, COMPARE, RESPOND) and the 3-bit result-flag struct (eq, gt, lt).
REQ-033 The comparison SHALL be implemented in one combinational sub-module, cmp_core, with WIDTH-wide A and B inputs and eq/gt/lt outputs; it SHALL honour SIGNED_CMP_EN.
REQ-034 Arbitration, operand latching and the FSM SHALL reside in cmp_arbiter.

Verification
REQ-035 Reset, then Req=0001, A0=3, B0=3 -> Grant=0001 at N+1; Done=1, Done_Id=0, A_E_B=1 at N+2; Busy=0 at N+3.
REQ-036 SIGNED_CMP_EN defined, Req=0010, A1=4'b1110 (-2), B1=4'b0001 -> A_L_B=1; same stimulus with the macro undefined -> A_G_B=1.
REQ-037 Req=1111 held high for 8 transactions -> Done_Id sequence 0,1,2,3,0,1,2,3 with one Done every 3 cycles.
REQ-038 Req=0100, A2=5, B2=2; change A2 to 0 in the cycle Grant appears -> A_G_B=1 (the latched value is used).
REQ-039 Reset pulsed in the COMPARE cycle -> no Done pulse, all outputs 0 the next cycle, next grant goes to the lowest set Req bit.
REQ-040 Req=1001 with last_served=0 -> requester 3 is granted before requester 0.
